ysyx_22050598_trap_seq: RTL

//  Trap sequencer: issuing side of the CSR trap interface. Accepts ecall/mret from EX, stalls the

---
 rtl/ysyx_22050598_trap_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/ysyx_22050598_trap_seq.sv
// Trap sequencer: stalls the pipeline on ecall/mret and waits for the LSU to drain.
// It then strobes the CSR unit once and hands the CSR-provided target PC to IF.
module ysyx_22050598_trap_seq #(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_inst_is_ecall_i,
  input  logic            ex_inst_is_mret_i,
  output logic            ex_trap_ready_o,
  input  logic            lsu_busy_i,
  output logic            csr_ecall_o,
  output logic            csr_mret_o,
  output logic [XLEN-1:0] csr_ecall_pc_o,
  input  logic [XLEN-1:0] csr_rd_pc_data_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic            drain_timeout_o
);

  localparam int CW = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_MAX);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, REDIRECT} state_t;

  state_t          state, state_next;
  logic            kind_ecall, kind_ecall_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] target_q, target_next;
  logic [CW-1:0]   cnt_q, cnt_next;
  logic            timeout_q, timeout_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kind_ecall <= 1'b0;
      pc_q       <= '0;
      target_q   <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_next;
      kind_ecall <= kind_ecall_next;
      pc_q       <= pc_next;
      target_q   <= target_next;
      cnt_q      <= cnt_next;
      timeout_q  <= timeout_next;
    end
  end

  always_comb begin
    state_next       = state;
    kind_ecall_next  = kind_ecall;
    pc_next          = pc_q;
    target_next      = target_q;
    cnt_next         = cnt_q;
    timeout_next     = timeout_q;
    ex_trap_ready_o  = 1'b0;
    stall_o          = 1'b1;
    csr_ecall_o      = 1'b0;
    csr_mret_o       = 1'b0;
    csr_ecall_pc_o   = '0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    drain_timeout_o  = timeout_q;

    case (state)
      IDLE: begin
        ex_trap_ready_o = 1'b1;
        stall_o         = 1'b0;
        // ecall takes priority when EX flags both kinds at once
        if (ex_valid_i && (ex_inst_is_ecall_i || ex_inst_is_mret_i)) begin
          kind_ecall_next = ex_inst_is_ecall_i;
          pc_next         = ex_pc_i;
          cnt_next        = '0;
          state_next      = DRAIN;
        end
      end
      DRAIN: begin
        if (!lsu_busy_i) begin
          state_next = ISSUE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_next = cnt_q + CW'(1);
          if (cnt_next == CNT_MAX) timeout_next = 1'b1;
        end
      end
      ISSUE: begin
        csr_ecall_o    = kind_ecall;
        csr_mret_o     = !kind_ecall;
        csr_ecall_pc_o = pc_q;
        flush_o        = 1'b1;
        target_next    = csr_rd_pc_data_i & ALIGN_MASK;
        state_next     = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
